pipeline_hazard_ctrl: RTL

- Pipeline sequencing controller for the mips32 five-stage core.
- Decides each cycle whether PC and the IF/ID register advance, hold or flush, and whether ID/EX receives a bubble.
- Handles three cases: load-use hazards, taken branches/jumps and instruction/data memory wait states.
- Keeps a memory-wait watchdog and saturating stall/flush performance counters.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 32 +++
 rtl/pipeline_hazard_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the mips32 pipeline control logic.
// Holds the sequencer state encoding and the load-use hazard test.
package mips_pkg;

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] LOADUSE = 2'd1;
  localparam logic [1:0] MEMWAIT = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A load in EX feeding a source of the ID instruction; $0 is never a real dependency.
  function automatic logic load_use_hazard(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt,
    input logic [4:0] ex_rt,
    input logic       ex_mem_read
  );
    return ex_mem_read && (ex_rt != REG_ZERO) &&
           ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencer: decides advance/hold/flush for PC, IF/ID and ID/EX,
// and tracks memory-wait watchdog plus stall/flush performance counters.
module pipeline_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int COUNT_W     = 16,
  parameter int WAIT_W      = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         ifIdRs,
  input  logic [4:0]         ifIdRt,
  input  logic               ifIdUsesRt,
  input  logic [4:0]         idExRt,
  input  logic               idExMemRead,
  input  logic               branchTaken,
  input  logic               jump,
  input  logic               imemReady,
  input  logic               dmemReady,
  output logic               pcWrite,
  output logic               ifIdWrite,
  output logic               ifIdFlush,
  output logic               idExFlush,
  output logic               pipeFreeze,
  output logic               memTimeout,
  output logic [COUNT_W-1:0] stallCycles,
  output logic [COUNT_W-1:0] flushCount
);

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic              mem_wait;
  logic              load_use;
  logic              stall_inc;

  assign mem_wait = !imemReady || !dmemReady;
  assign load_use = load_use_hazard(ifIdRs, ifIdRt, ifIdUsesRt, idExRt, idExMemRead);

  always_comb begin
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    idExFlush  = 1'b0;
    pipeFreeze = 1'b0;
    state_d    = RUN;
    wait_cnt_d = '0;

    if (state_q == MEMWAIT) begin
      // Release cycle stays frozen too; the pipeline resumes from RUN next cycle.
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      pipeFreeze = 1'b1;
      if (mem_wait) begin
        state_d    = MEMWAIT;
        wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 1'b1;
      end
    end else if (mem_wait) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      pipeFreeze = 1'b1;
      state_d    = MEMWAIT;
    end else if (branchTaken) begin
      ifIdFlush = 1'b1;
      idExFlush = 1'b1;
    end else if (load_use && (state_q != LOADUSE)) begin
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
      idExFlush = 1'b1;
      state_d   = LOADUSE;
    end else if (jump) begin
      ifIdFlush = 1'b1;
    end
  end

  assign mem_timeout_d = mem_timeout_q || (wait_cnt_d >= TIMEOUT_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign memTimeout = mem_timeout_q;
  assign stall_inc  = !pcWrite;

  sat_counter #(.W(COUNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stallCycles)
  );

  sat_counter #(.W(COUNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ifIdFlush),
    .count (flushCount)
  );

endmodule
